// File: rtl/serial_sub.sv
// Digit-serial borrow-look-ahead subtractor, one nibble per cycle LSB first; result valid Dw/4 cycles after accept.
// ready_o only in IDLE; result held in DONE until ready_i, stalling indefinitely under backpressure.
module serial_sub #(
  parameter int Dw = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [Dw-1:0] a_i,
  input  logic [Dw-1:0] b_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [Dw-1:0] d_o,
  output logic          borrow_o,
  output logic          ovf_o
);

  localparam int N  = Dw / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (Dw % 4 != 0) begin : g_bad_width
    $fatal(1, "serial_sub: Dw must be a multiple of 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [Dw-1:0]   a_q, b_q, d_q;
  logic            a_msb_q, b_msb_q;
  logic [CW-1:0]   cnt_q;
  logic            bw_q;
  logic            last_nib;
  logic [3:0]      g, p, diff;
  logic [4:0]      bw;

  assign last_nib = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)  state_d = BUSY;
      BUSY:    if (last_nib) state_d = DONE;
      DONE:    if (ready_i)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
  end

  // Flattened look-ahead: each borrow is a two-level sum of products over g, p and the incoming borrow.
  always_comb begin
    g     = ~a_q[3:0] & b_q[3:0];
    p     = ~(a_q[3:0] ^ b_q[3:0]);
    bw[0] = bw_q;
    bw[1] = g[0] | (p[0] & bw_q);
    bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_q);
    bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw_q);
    bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bw_q);
    diff  = a_q[3:0] ^ b_q[3:0] ^ bw[3:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
    end else if (state_q == IDLE && valid_i) begin
      a_q     <= a_i;
      b_q     <= b_i;
      a_msb_q <= a_i[Dw-1];
      b_msb_q <= b_i[Dw-1];
      cnt_q   <= '0;
      bw_q    <= 1'b0;
    end else if (state_q == BUSY) begin
      // Operands shift down so the active nibble always sits at bits [3:0].
      a_q                 <= a_q >> 4;
      b_q                 <= b_q >> 4;
      d_q[4*cnt_q +: 4]   <= diff;
      bw_q                <= bw[4];
      if (!last_nib) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign d_o      = d_q;
  assign borrow_o = valid_o & bw_q;
  assign ovf_o    = valid_o & (a_msb_q ^ b_msb_q) & (d_q[Dw-1] ^ a_msb_q);

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed Dw=8 scenarios plus randomized sweeps at Dw = 4, 8, 32
// checked against an arithmetic model of modular difference, unsigned borrow and signed overflow.
module tb_serial_sub;

  localparam int OPS   = 3000;
  localparam int LIMIT = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: integer arithmetic on the operand values, independent of any nibble structure.
  function automatic void ref_sub(input int w, input longint unsigned a, input longint unsigned b,
                                  output longint unsigned d, output logic bo, output logic ov);
    longint unsigned m;
    longint half, sa, sb, sd;
    m    = (64'h1 << w) - 64'h1;
    half = longint'(64'h1 << (w - 1));
    d    = (a - b) & m;
    bo   = (a < b);
    sa   = (a >= longint'(half)) ? longint'(a) - 2 * half : longint'(a);
    sb   = (b >= longint'(half)) ? longint'(b) - 2 * half : longint'(b);
    sd   = sa - sb;
    ov   = (sd >= half) || (sd < -half);
  endfunction

  // ---------------- directed instance, Dw = 8 ----------------
  logic       drst_n, dvi, dro, dvo, dri, dbo, dov;
  logic [7:0] da, db, dd;

  serial_sub #(.Dw(8)) u_dir (
    .clk_i(clk), .rst_ni(drst_n), .valid_i(dvi), .ready_o(dro), .a_i(da), .b_i(db),
    .valid_o(dvo), .ready_i(dri), .d_o(dd), .borrow_o(dbo), .ovf_o(dov)
  );

  task automatic dir_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo, input int hold);
    longint unsigned md;
    logic mb, mo;
    logic [7:0] held;
    int k;
    ref_sub(8, 64'(a), 64'(b), md, mb, mo);
    chk({nm, " model d"}, md, 64'(ed));
    chk({nm, " model borrow"}, 64'(mb), 64'(eb));
    chk({nm, " model ovf"}, 64'(mo), 64'(eo));
    @(negedge clk);
    chk({nm, " ready_o idle"}, 64'(dro), 64'd1);
    dvi = 1'b1; da = a; db = b; dri = (hold == 0);
    @(negedge clk);
    dvi = 1'b0; da = 8'h5A; db = 8'hC3;
    k = 1;
    while (!dvo && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'd3);
    chk({nm, " d_o"}, 64'(dd), 64'(ed));
    chk({nm, " borrow_o"}, 64'(dbo), 64'(eb));
    chk({nm, " ovf_o"}, 64'(dov), 64'(eo));
    held = dd;
    for (int i = 0; i < hold; i++) begin
      dvi = 1'b1; da = 8'hAA; db = 8'h11;
      @(negedge clk);
      chk({nm, " stall d_o"}, 64'(dd), 64'(held));
      chk({nm, " stall ready_o"}, 64'(dro), 64'd0);
      chk({nm, " stall valid_o"}, 64'(dvo), 64'd1);
    end
    dri = 1'b1; dvi = 1'b0;
    @(negedge clk);
    chk({nm, " valid_o after handoff"}, 64'(dvo), 64'd0);
    chk({nm, " ready_o after handoff"}, 64'(dro), 64'd1);
    chk({nm, " d_o held in idle"}, 64'(dd), 64'(ed));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " ready_o"}, 64'(dro), 64'd1);
    chk({nm, " valid_o"}, 64'(dvo), 64'd0);
    chk({nm, " d_o"}, 64'(dd), 64'd0);
    chk({nm, " borrow_o"}, 64'(dbo), 64'd0);
    chk({nm, " ovf_o"}, 64'(dov), 64'd0);
  endtask

  // ---------------- randomized instances ----------------
  logic rrst_n;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 8 : 32);
    localparam int N = W / 4;
    logic          vi, ro, vo, ri, bo, ov, done;
    logic [W-1:0]  a, b, d;
    logic [W-1:0]  qd[$];
    logic          qb[$];
    logic          qo[$];

    serial_sub #(.Dw(W)) u_dut (
      .clk_i(clk), .rst_ni(rrst_n), .valid_i(vi), .ready_o(ro), .a_i(a), .b_i(b),
      .valid_o(vo), .ready_i(ri), .d_o(d), .borrow_o(bo), .ovf_o(ov)
    );

    function automatic logic [W-1:0] pick();
      logic [31:0]  r;
      logic [W-1:0] v;
      r = $urandom;
      v = r[W-1:0];
      case ($urandom_range(0, 5))
        0: v = '0;
        1: v = '1;
        2: begin v = '0; v[W-1] = 1'b1; end
        default: ;
      endcase
      return v;
    endfunction

    initial begin
      int n_acc, cyc, acc_cyc;
      bit seen;
      longint unsigned md;
      logic mb, mo;
      n_acc = 0; cyc = 0; acc_cyc = 0; seen = 1'b0;
      vi = 1'b0; ri = 1'b0; a = '0; b = '0; done = 1'b0;
      @(posedge rrst_n);
      while ((n_acc < OPS || qd.size() != 0) && cyc < LIMIT) begin
        @(negedge clk);
        cyc++;
        if (vo) begin
          if (qd.size() == 0) begin
            fail($sformatf("w%0d spurious valid_o", W));
          end else begin
            chk($sformatf("w%0d d_o", W), 64'(d), 64'(qd[0]));
            chk($sformatf("w%0d borrow_o", W), 64'(bo), 64'(qb[0]));
            chk($sformatf("w%0d ovf_o", W), 64'(ov), 64'(qo[0]));
            if (!seen) begin
              chk($sformatf("w%0d latency", W), 64'(cyc - acc_cyc), 64'(N + 1));
              seen = 1'b1;
            end
          end
        end
        if (qd.size() != 0) chk($sformatf("w%0d ready_o while busy", W), 64'(ro), 64'd0);
        ri = ($urandom_range(0, 3) != 0);
        if (vo && ri && qd.size() != 0) begin
          void'(qd.pop_front());
          void'(qb.pop_front());
          void'(qo.pop_front());
        end
        vi = (n_acc < OPS) && ($urandom_range(0, 7) != 0);
        a  = pick();
        b  = pick();
        if (vi && ro) begin
          ref_sub(W, 64'(a), 64'(b), md, mb, mo);
          qd.push_back(md[W-1:0]);
          qb.push_back(mb);
          qo.push_back(mo);
          n_acc++;
          acc_cyc = cyc;
          seen = 1'b0;
        end
      end
      if (cyc >= LIMIT) fail($sformatf("w%0d timeout after %0d ops", W, n_acc));
      vi = 1'b0;
      done = 1'b1;
    end
  end

  // ---------------- sequencing ----------------
  initial begin
    drst_n = 1'b0; rrst_n = 1'b0;
    dvi = 1'b0; dri = 1'b0; da = '0; db = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    drst_n = 1'b1;
    rrst_n = 1'b1;

    dir_op("basic",     8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 0);
    dir_op("nib_borrow", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0);
    dir_op("zero_m1",   8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0);
    dir_op("ovf_neg",   8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    dir_op("ovf_pos",   8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    dir_op("backpress", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 5);
    dir_op("bp_next",   8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0, 0);

    @(negedge clk);
    dvi = 1'b1; da = 8'h35; db = 8'h12; dri = 1'b1;
    @(negedge clk);
    dvi = 1'b0;
    chk("mid_busy ready_o", 64'(dro), 64'd0);
    drst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_busy reset");
    @(negedge clk);
    drst_n = 1'b1;
    dir_op("after_reset", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 0);

    wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
